execute_stage: RTL and testbench

- Pipeline E register plus execute stage of the 5-stage Y86-64 pipeline; sits directly downstream of decode/write-back.
- Latches the decode outputs (d_*) on each clock and computes the ALU result and the CMOVXX/JXX condition.
- Holds the condition-code register (ZF/SF/OF).
- Drives the e_dstE/e_valE bypass back to decode and the E_* fields to the hazard unit and the M register.

---
 rtl/execute_stage.sv | 279 +++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//
// Pipeline E register plus the execute stage of a 5-stage Y86-64 pipeline.
// On every rising clock edge the decode outputs (d_*) are captured into the
// E register, unless a reset or a bubble is requested. A bubble turns the slot
// into a nop. The stage has no stall input, so E never holds its contents.
// The ALU result, the CMOVXX/JXX condition and the bypass destination are
// all computed combinationally from the E register in the same cycle.
// The stage also owns the condition-code register {ZF,SF,OF}.
//
// Optional feature macro: EXEC_OPCNT_EN
//   When defined, this file adds the op_count output. It is a 32-bit count of
//   the clock edges on which the condition codes were written. The counter
//   wraps.
//
// Ports
//   clk, reset          pipeline clock (rising edge), synchronous active-high reset
//   E_bubble            load a nop bubble into E this edge
//   d_*                 decode-stage outputs captured into E
//   m_stat, W_stat      downstream status; an exception there blocks CC writes
//   E_icode/E_dstM/E_srcA/E_srcB   registered fields for the hazard unit
//   e_stat/e_icode/e_valA/e_dstM   copies of E fields toward the M register
//   e_Cnd               condition result (meaningful for cmovXX / jXX)
//   e_valE              ALU result
//   e_dstE              effective destination (RNONE for a cmov not taken)
//   cc                  {ZF,SF,OF} register contents
//   op_count            (EXEC_OPCNT_EN only) count of CC-write edges
// ----------------------------------------------------------------------------
module execute_stage #(
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [2:0] STAT_AOK = 3'd1,
   parameter logic [2:0] STAT_HLT = 3'd2,
   parameter logic [2:0] STAT_ADR = 3'd3,
   parameter logic [2:0] STAT_INS = 3'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_bubble,
   input  logic [2:0]  d_stat,
   input  logic [3:0]  d_icode,
   input  logic [3:0]  d_ifun,
   input  logic [63:0] d_valC,
   input  logic [63:0] d_valA,
   input  logic [63:0] d_valB,
   input  logic [3:0]  d_dstE,
   input  logic [3:0]  d_dstM,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [2:0]  m_stat,
   input  logic [2:0]  W_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB,
   output logic [2:0]  e_stat,
   output logic [3:0]  e_icode,
   output logic        e_Cnd,
   output logic [63:0] e_valE,
   output logic [63:0] e_valA,
   output logic [3:0]  e_dstE,
   output logic [3:0]  e_dstM,
   output logic [2:0]  cc
`ifdef EXEC_OPCNT_EN
   ,
   output logic [31:0] op_count
`endif
);

   // Instruction codes that steer the ALU operand selection
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // ALU function codes (OPq ifun)
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   // Condition codes live in cc_reg as {ZF,SF,OF}
   localparam logic [2:0] CC_RESET = 3'b100;

   // ------------------------------------------------------------------------
   // E register
   // ------------------------------------------------------------------------
   logic [2:0]  ex_stat_reg;
   logic [3:0]  ex_icode_reg;
   logic [3:0]  ex_ifun_reg;
   logic [63:0] ex_valc_reg;
   logic [63:0] ex_vala_reg;
   logic [63:0] ex_valb_reg;
   logic [3:0]  ex_dste_reg;
   logic [3:0]  ex_dstm_reg;
   logic [3:0]  ex_srca_reg;
   logic [3:0]  ex_srcb_reg;

   always_ff @(posedge clk) begin
      if (reset || E_bubble) begin
         // A reset and a bubble both leave a plain nop in the slot
         ex_stat_reg  <= STAT_AOK;
         ex_icode_reg <= I_NOP;
         ex_ifun_reg  <= 4'h0;
         ex_valc_reg  <= 64'd0;
         ex_vala_reg  <= 64'd0;
         ex_valb_reg  <= 64'd0;
         ex_dste_reg  <= RNONE;
         ex_dstm_reg  <= RNONE;
         ex_srca_reg  <= RNONE;
         ex_srcb_reg  <= RNONE;
      end else begin
         ex_stat_reg  <= d_stat;
         ex_icode_reg <= d_icode;
         ex_ifun_reg  <= d_ifun;
         ex_valc_reg  <= d_valC;
         ex_vala_reg  <= d_valA;
         ex_valb_reg  <= d_valB;
         ex_dste_reg  <= d_dstE;
         ex_dstm_reg  <= d_dstM;
         ex_srca_reg  <= d_srcA;
         ex_srcb_reg  <= d_srcB;
      end
   end

   // ------------------------------------------------------------------------
   // ALU operand selection
   // ------------------------------------------------------------------------
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_fun;

   always_comb begin
      alu_a = 64'd0;
      unique case (ex_icode_reg)
         I_RRMOVQ, I_OPQ:             alu_a = ex_vala_reg;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex_valc_reg;
         I_CALL, I_PUSHQ:             alu_a = -64'sd8;
         I_RET, I_POPQ:               alu_a = 64'd8;
         default:                     alu_a = 64'd0;
      endcase
   end

   always_comb begin
      alu_b = 64'd0;
      unique case (ex_icode_reg)
         I_RMMOVQ, I_MRMOVQ, I_OPQ,
         I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = ex_valb_reg;
         default:                        alu_b = 64'd0;
      endcase
   end

   assign alu_fun = (ex_icode_reg == I_OPQ) ? ex_ifun_reg : ALU_ADD;

   // ------------------------------------------------------------------------
   // ALU and new condition codes
   // ------------------------------------------------------------------------
   logic [63:0] alu_out;
   logic        alu_fun_ok;
   logic        new_zf;
   logic        new_sf;
   logic        new_of;

   always_comb begin
      alu_out    = 64'd0;
      alu_fun_ok = 1'b1;
      new_of     = 1'b0;
      unique case (alu_fun)
         ALU_ADD: begin
            alu_out = alu_b + alu_a;
            new_of  = (alu_a[63] == alu_b[63]) && (alu_out[63] != alu_a[63]);
         end
         ALU_SUB: begin
            alu_out = alu_b - alu_a;
            new_of  = (alu_b[63] != alu_a[63]) && (alu_out[63] != alu_b[63]);
         end
         ALU_AND: alu_out = alu_b & alu_a;
         ALU_XOR: alu_out = alu_b ^ alu_a;
         default: begin
            // Undefined OPq function: produce zero and leave the CCs alone
            alu_out    = 64'd0;
            alu_fun_ok = 1'b0;
         end
      endcase
   end

   assign new_zf = (alu_out == 64'd0);
   assign new_sf = alu_out[63];

   // Any exception further down the pipe means this OPq must not be
   // allowed to affect architectural state.
   logic m_exc;
   logic w_exc;
   logic set_cc;

   assign m_exc  = (m_stat == STAT_ADR) || (m_stat == STAT_INS) || (m_stat == STAT_HLT);
   assign w_exc  = (W_stat == STAT_ADR) || (W_stat == STAT_INS) || (W_stat == STAT_HLT);
   assign set_cc = (ex_icode_reg == I_OPQ) && alu_fun_ok && !m_exc && !w_exc;

   // ------------------------------------------------------------------------
   // Condition-code register (reset only; a bubble leaves it untouched)
   // ------------------------------------------------------------------------
   logic [2:0] cc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cc_reg <= CC_RESET;
      end else if (set_cc) begin
         cc_reg <= {new_zf, new_sf, new_of};
      end
   end

   // ------------------------------------------------------------------------
   // Condition evaluation uses the CC value from before this instruction's
   // own update. The decoding is shared by cmovXX and jXX.
   // ------------------------------------------------------------------------
   logic cc_zf;
   logic cc_sf;
   logic cc_of;
   logic cc_lt;
   logic cnd;

   assign {cc_zf, cc_sf, cc_of} = cc_reg;
   assign cc_lt = cc_sf ^ cc_of;

   always_comb begin
      cnd = 1'b0;
      unique case (ex_ifun_reg)
         4'h0:    cnd = 1'b1;
         4'h1:    cnd = cc_lt | cc_zf;
         4'h2:    cnd = cc_lt;
         4'h3:    cnd = cc_zf;
         4'h4:    cnd = ~cc_zf;
         4'h5:    cnd = ~cc_lt;
         4'h6:    cnd = ~cc_lt & ~cc_zf;
         default: cnd = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign E_icode = ex_icode_reg;
   assign E_dstM  = ex_dstm_reg;
   assign E_srcA  = ex_srca_reg;
   assign E_srcB  = ex_srcb_reg;

   assign e_stat  = ex_stat_reg;
   assign e_icode = ex_icode_reg;
   assign e_valA  = ex_vala_reg;
   assign e_dstM  = ex_dstm_reg;
   assign e_Cnd   = cnd;
   assign e_valE  = alu_out;
   assign cc      = cc_reg;

   // A conditional move whose condition fails must not write its target
   assign e_dstE  = ((ex_icode_reg == I_RRMOVQ) && !cnd) ? RNONE : ex_dste_reg;

`ifdef EXEC_OPCNT_EN
   logic [31:0] op_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_count_reg <= 32'd0;
      end else if (set_cc) begin
         op_count_reg <= op_count_reg + 32'd1;
      end
   end

   assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
//
// Self-checking bench for execute_stage. It runs directed scenarios first:
// reset, addq, exception-gated subq, cmovle, stack arithmetic, and bubble
// versus reset. It then runs a randomized stream that is compared every cycle
// against an instruction-level model of the execute stage.
// ----------------------------------------------------------------------------
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_bubble;
   logic [2:0]  d_stat;
   logic [3:0]  d_icode;
   logic [3:0]  d_ifun;
   logic [63:0] d_valC;
   logic [63:0] d_valA;
   logic [63:0] d_valB;
   logic [3:0]  d_dstE;
   logic [3:0]  d_dstM;
   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [2:0]  m_stat;
   logic [2:0]  W_stat;
   logic [3:0]  E_icode;
   logic [3:0]  E_dstM;
   logic [3:0]  E_srcA;
   logic [3:0]  E_srcB;
   logic [2:0]  e_stat;
   logic [3:0]  e_icode;
   logic        e_Cnd;
   logic [63:0] e_valE;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic [2:0]  cc;
`ifdef EXEC_OPCNT_EN
   logic [31:0] op_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk      (clk),
      .reset    (reset),
      .E_bubble (E_bubble),
      .d_stat   (d_stat),
      .d_icode  (d_icode),
      .d_ifun   (d_ifun),
      .d_valC   (d_valC),
      .d_valA   (d_valA),
      .d_valB   (d_valB),
      .d_dstE   (d_dstE),
      .d_dstM   (d_dstM),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .E_icode  (E_icode),
      .E_dstM   (E_dstM),
      .E_srcA   (E_srcA),
      .E_srcB   (E_srcB),
      .e_stat   (e_stat),
      .e_icode  (e_icode),
      .e_Cnd    (e_Cnd),
      .e_valE   (e_valE),
      .e_valA   (e_valA),
      .e_dstE   (e_dstE),
      .e_dstM   (e_dstM),
      .cc       (cc)
`ifdef EXEC_OPCNT_EN
      ,
      .op_count (op_count)
`endif
   );

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic set_instr(input logic [3:0] icode, input logic [3:0] ifun,
                            input logic [63:0] vala, input logic [63:0] valb,
                            input logic [63:0] valc, input logic [3:0] dste);
      d_stat  = 3'd1;
      d_icode = icode;
      d_ifun  = ifun;
      d_valA  = vala;
      d_valB  = valb;
      d_valC  = valc;
      d_dstE  = dste;
      d_dstM  = 4'hF;
      d_srcA  = 4'hF;
      d_srcB  = 4'hF;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // The model computes each instruction's effect at the instruction level.
   // It covers the result value, the condition outcome, the resulting
   // condition codes, and whether that instruction is an OPq that writes the
   // CCs.
   task automatic model_exec(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [2:0] ccv,
                             output logic [63:0] ve, output logic cnd,
                             output logic [2:0] ncc, output logic is_op);
      logic signed [64:0] wide;
      logic zf, sf, of, lt, ovf;
      ve = 64'd0;
      ovf = 1'b0;
      is_op = 1'b0;
      case (ic)
         4'h2: ve = a;              // rrmovq / cmovXX
         4'h3: ve = c;              // irmovq
         4'h4, 4'h5: ve = b + c;    // effective address
         4'h6: begin
            is_op = (fn <= 4'd3);
            case (fn)
               4'd0: begin
                  wide = $signed({a[63], a}) + $signed({b[63], b});
                  ve = wide[63:0];
                  ovf = (wide[64] != wide[63]);
               end
               4'd1: begin
                  wide = $signed({b[63], b}) - $signed({a[63], a});
                  ve = wide[63:0];
                  ovf = (wide[64] != wide[63]);
               end
               4'd2: ve = a & b;
               4'd3: ve = a ^ b;
               default: ve = 64'd0;
            endcase
         end
         4'h8, 4'hA: ve = b - 64'd8; // call / pushq: stack grows down
         4'h9, 4'hB: ve = b + 64'd8; // ret / popq
         default: ve = 64'd0;
      endcase
      ncc = {(ve == 64'd0), ve[63], ovf};
      zf = ccv[2];
      sf = ccv[1];
      of = ccv[0];
      lt = sf ^ of;
      case (fn)
         4'd0: cnd = 1'b1;
         4'd1: cnd = lt || zf;
         4'd2: cnd = lt;
         4'd3: cnd = zf;
         4'd4: cnd = !zf;
         4'd5: cnd = !lt;
         4'd6: cnd = !lt && !zf;
         default: cnd = 1'b0;
      endcase
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      set_instr(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2);
      step();
      reset = 1'b0;
      checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL reset_icode: got %h expected 1", E_icode); end
      checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE: got %h expected f", e_dstE); end
      checks++; if (E_dstM !== 4'hF) begin errors++; $display("FAIL reset_dstM: got %h expected f", E_dstM); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b expected 100", cc); end
      checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL reset_valE: got %h expected 0", e_valE); end
      checks++; if (e_stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d expected 1", e_stat); end
      $display("test_reset done");
   endtask

   task automatic test_addq();
      m_stat = 3'd1;
      W_stat = 3'd1;
      set_instr(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3);
      step();
      checks++; if (e_valE !== 64'd12) begin errors++; $display("FAIL addq_valE: got %h expected c", e_valE); end
      checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL addq_dstE: got %h expected 3", e_dstE); end
      set_instr(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h4);
      step();
      checks++; if (cc !== 3'b000) begin errors++; $display("FAIL addq_cc1: got %b expected 000", cc); end
      checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL addq_ovf_valE: got %h expected 8000000000000000", e_valE); end
      set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      step();
      checks++; if (cc !== 3'b011) begin errors++; $display("FAIL addq_cc2: got %b expected 011", cc); end
      $display("test_addq done");
   endtask

   task automatic test_sub_gated();
      set_instr(4'h6, 4'h1, 64'd9, 64'd9, 64'd0, 4'h5);
      step();
      checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL sub_valE: got %h expected 0", e_valE); end
      m_stat = 3'd3;
      set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      step();
      checks++; if (cc !== 3'b011) begin errors++; $display("FAIL sub_gated_cc: got %b expected 011", cc); end
      m_stat = 3'd1;
      set_instr(4'h6, 4'h1, 64'd9, 64'd9, 64'd0, 4'h5);
      step();
      set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      step();
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL sub_cc: got %b expected 100", cc); end
      $display("test_sub_gated done");
   endtask

   task automatic test_cmov();
      set_instr(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3);
      step();
      set_instr(4'h2, 4'h1, 64'd44, 64'd0, 64'd0, 4'h6);
      step();
      checks++; if (cc !== 3'b000) begin errors++; $display("FAIL cmov_cc: got %b expected 000", cc); end
      checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cmov_cnd: got %b expected 0", e_Cnd); end
      checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL cmov_dstE: got %h expected f", e_dstE); end
      checks++; if (e_valE !== 64'd44) begin errors++; $display("FAIL cmov_valE: got %h expected 2c", e_valE); end
      // cmovne under ZF=0 is taken and keeps its destination
      set_instr(4'h2, 4'h4, 64'd45, 64'd0, 64'd0, 4'h6);
      step();
      checks++; if (e_dstE !== 4'h6) begin errors++; $display("FAIL cmovne_dstE: got %h expected 6", e_dstE); end
      $display("test_cmov done");
   endtask

   task automatic test_stack();
      set_instr(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
      step();
      checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL call_valE: got %h expected f8", e_valE); end
      set_instr(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'h4);
      step();
      checks++; if (e_valE !== 64'h100) begin errors++; $display("FAIL pop_valE: got %h expected 100", e_valE); end
      $display("test_stack done");
   endtask

   task automatic test_bubble();
      logic [2:0] cc_before;
      cc_before = cc;
      E_bubble = 1'b1;
      set_instr(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
      step();
      E_bubble = 1'b0;
      checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL bubble_icode: got %h expected 1", E_icode); end
      set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      step();
      checks++; if (cc !== cc_before) begin errors++; $display("FAIL bubble_cc: got %b expected %b", cc, cc_before); end
      // An addq in E would clear ZF, but reset wins in the same edge
      set_instr(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3);
      step();
      reset = 1'b1;
      E_bubble = 1'b1;
      step();
      reset = 1'b0;
      E_bubble = 1'b0;
      checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL rstbub_icode: got %h expected 1", E_icode); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rstbub_cc: got %b expected 100", cc); end
      checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL rstbub_dstE: got %h expected f", e_dstE); end
      $display("test_bubble done");
   endtask

   // ---------------- randomized stream vs model ----------------
   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = 64'd0;
         1: v = 64'h7FFF_FFFF_FFFF_FFFF;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'd8;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic test_random();
      logic [2:0]  m_st, m_ic_unused;
      logic [2:0]  mst, mcc;
      logic [3:0]  mic, mfn, mdste, mdstm, msrca, msrcb;
      logic [63:0] mva, mvb, mvc, ve;
      logic        cnd, is_op, do_rst, do_bub, wr;
      logic [2:0]  ncc;
      logic [31:0] mcount;
      m_ic_unused = 3'd0;
      m_st = 3'd0;
      // start from a known state
      reset = 1'b1;
      step();
      reset = 1'b0;
      mst = 3'd1; mic = 4'h1; mfn = 4'h0; mva = 0; mvb = 0; mvc = 0;
      mdste = 4'hF; mdstm = 4'hF; msrca = 4'hF; msrcb = 4'hF;
      mcc = 3'b100;
      mcount = 32'd0;
      for (int n = 0; n < 400; n++) begin
         do_rst = ($urandom_range(0, 39) == 0);
         do_bub = ($urandom_range(0, 7) == 0);
         d_stat  = 3'($urandom_range(0, 4));
         d_icode = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) d_icode = 4'h6;
         d_ifun  = 4'($urandom_range(0, 7));
         d_valA  = pick_operand();
         d_valB  = ($urandom_range(0, 4) == 0) ? d_valA : pick_operand();
         d_valC  = pick_operand();
         d_dstE  = 4'($urandom_range(0, 15));
         d_dstM  = 4'($urandom_range(0, 15));
         d_srcA  = 4'($urandom_range(0, 15));
         d_srcB  = 4'($urandom_range(0, 15));
         m_stat  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
         W_stat  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
         reset    = do_rst;
         E_bubble = do_bub;
         // effect of the instruction currently in E at this edge
         model_exec(mic, mfn, mva, mvb, mvc, mcc, ve, cnd, ncc, is_op);
         wr = is_op && !(m_stat inside {3'd2, 3'd3, 3'd4}) && !(W_stat inside {3'd2, 3'd3, 3'd4});
         if (do_rst) begin
            mcc = 3'b100;
            mcount = 32'd0;
         end else if (wr) begin
            mcc = ncc;
            mcount = mcount + 32'd1;
         end
         if (do_rst || do_bub) begin
            mst = 3'd1; mic = 4'h1; mfn = 4'h0; mva = 0; mvb = 0; mvc = 0;
            mdste = 4'hF; mdstm = 4'hF; msrca = 4'hF; msrcb = 4'hF;
         end else begin
            mst = d_stat; mic = d_icode; mfn = d_ifun; mva = d_valA; mvb = d_valB;
            mvc = d_valC; mdste = d_dstE; mdstm = d_dstM; msrca = d_srcA; msrcb = d_srcB;
         end
         step();
         reset = 1'b0;
         E_bubble = 1'b0;
         model_exec(mic, mfn, mva, mvb, mvc, mcc, ve, cnd, ncc, is_op);
         checks++; if (e_valE !== ve) begin errors++; $display("FAIL rnd_valE[%0d]: icode %h ifun %h got %h expected %h", n, mic, mfn, e_valE, ve); end
         checks++; if (cc !== mcc) begin errors++; $display("FAIL rnd_cc[%0d]: got %b expected %b", n, cc, mcc); end
         if (mic == 4'h2 || mic == 4'h7) begin
            checks++; if (e_Cnd !== cnd) begin errors++; $display("FAIL rnd_cnd[%0d]: icode %h ifun %h got %b expected %b", n, mic, mfn, e_Cnd, cnd); end
         end
         checks++;
         if (e_dstE !== ((mic == 4'h2 && !cnd) ? 4'hF : mdste)) begin
            errors++; $display("FAIL rnd_dstE[%0d]: got %h expected %h", n, e_dstE, (mic == 4'h2 && !cnd) ? 4'hF : mdste);
         end
         checks++;
         if ({e_stat, e_icode, E_icode, e_dstM, E_dstM, E_srcA, E_srcB} !== {mst, mic, mic, mdstm, mdstm, msrca, msrcb}) begin
            errors++; $display("FAIL rnd_fields[%0d]: got %h expected %h", n,
                               {e_stat, e_icode, E_icode, e_dstM, E_dstM, E_srcA, E_srcB},
                               {mst, mic, mic, mdstm, mdstm, msrca, msrcb});
         end
         checks++; if (e_valA !== mva) begin errors++; $display("FAIL rnd_valA[%0d]: got %h expected %h", n, e_valA, mva); end
`ifdef EXEC_OPCNT_EN
         checks++; if (op_count !== mcount) begin errors++; $display("FAIL rnd_opcount[%0d]: got %0d expected %0d", n, op_count, mcount); end
`endif
      end
      $display("test_random done (%0d CC writes in final epoch)", mcount);
   endtask

   initial begin
      reset    = 1'b0;
      E_bubble = 1'b0;
      m_stat   = 3'd1;
      W_stat   = 3'd1;
      set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      #2;
      test_reset();
      test_addq();
      test_sub_gated();
      test_cmov();
      test_stack();
      test_bubble();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
